// File: rtl/card_decider.sv
// Frame-rate card decision: snapshot 17 scores, serially pick lowest rank/suit, reject weak frames, filter.
// Optional macro CARD_DECIDER_HYST_EN enables the STABLE_FRAMES consecutive-candidate filter.
module card_decider #(
  parameter int unsigned SCORE_W       = 11,
  parameter int unsigned MAX_SCORE     = 1500,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   frame_done_in,
  input  logic [13*SCORE_W-1:0]  rank_scores_in,
  input  logic [4*SCORE_W-1:0]   suit_scores_in,
  output logic [5:0]             card_map_out,
  output logic [SCORE_W-1:0]     rank_score_out,
  output logic [SCORE_W-1:0]     suit_score_out,
  output logic                   card_valid_out,
  output logic                   busy_out
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SNAP      = 3'd1,
    S_SCAN_RANK = 3'd2,
    S_SCAN_SUIT = 3'd3,
    S_DECIDE    = 3'd4
  } state_t;

  localparam logic [SCORE_W-1:0] MAX_C = SCORE_W'(MAX_SCORE);

  state_t               state_q, state_d;
  logic [3:0]           idx_q, idx_d;
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [3:0]           best_idx_q, best_idx_d;
  logic [SCORE_W-1:0]   rank_best_q, rank_best_d;
  logic [3:0]           rank_idx_q, rank_idx_d;
  logic [SCORE_W-1:0]   snap_rank_q [13];
  logic [SCORE_W-1:0]   snap_suit_q [4];
  logic                 snap_load_s;
  logic [SCORE_W-1:0]   cur_score_s;
  logic                 upd_s;
  logic [SCORE_W-1:0]   best_new_s;
  logic [3:0]           best_idx_new_s;
  logic                 busy_d, busy_q;
  logic [5:0]           card_map_q;
  logic [SCORE_W-1:0]   rank_score_q, suit_score_q;
  logic                 card_valid_q;
  logic                 decide_s, reject_s, publish_s;
  logic [5:0]           cand_s;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (frame_done_in) state_d = S_SNAP; else state_d = S_IDLE;
      S_SNAP:      state_d = S_SCAN_RANK;
      S_SCAN_RANK: if (idx_q == 4'd12) state_d = S_SCAN_SUIT; else state_d = S_SCAN_RANK;
      S_SCAN_SUIT: if (idx_q == 4'd3) state_d = S_DECIDE; else state_d = S_SCAN_SUIT;
      S_DECIDE:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // busy is registered from the next state so it covers SNAP through DECIDE
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    decide_s = (state_q == S_DECIDE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 13; i++) snap_rank_q[i] <= '0;
      for (int i = 0; i < 4; i++)  snap_suit_q[i] <= '0;
    end else if (snap_load_s) begin
      for (int i = 0; i < 13; i++) snap_rank_q[i] <= rank_scores_in[i*SCORE_W +: SCORE_W];
      for (int i = 0; i < 4; i++)  snap_suit_q[i] <= suit_scores_in[i*SCORE_W +: SCORE_W];
    end
  end

  // Strict less-than keeps the lower index on ties
  always_comb begin
    if (state_q == S_SCAN_RANK) begin
      cur_score_s = snap_rank_q[idx_q];
    end else begin
      cur_score_s = snap_suit_q[idx_q[1:0]];
    end
    upd_s          = (cur_score_s < best_q);
    best_new_s     = upd_s ? cur_score_s : best_q;
    best_idx_new_s = upd_s ? idx_q : best_idx_q;
  end

  always_comb begin
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    rank_best_d = rank_best_q;
    rank_idx_d  = rank_idx_q;
    snap_load_s = 1'b0;
    case (state_q)
      S_IDLE: snap_load_s = frame_done_in;
      S_SNAP: begin
        idx_d      = 4'd0;
        best_d     = '1;
        best_idx_d = 4'd0;
      end
      S_SCAN_RANK: begin
        if (idx_q == 4'd12) begin
          rank_best_d = best_new_s;
          rank_idx_d  = best_idx_new_s;
          idx_d       = 4'd0;
          best_d      = '1;
          best_idx_d  = 4'd0;
        end else begin
          idx_d      = idx_q + 4'd1;
          best_d     = best_new_s;
          best_idx_d = best_idx_new_s;
        end
      end
      S_SCAN_SUIT: begin
        idx_d      = idx_q + 4'd1;
        best_d     = best_new_s;
        best_idx_d = best_idx_new_s;
      end
      S_DECIDE: idx_d = idx_q;
      default:  idx_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_q       <= 4'd0;
      best_q      <= '1;
      best_idx_q  <= 4'd0;
      rank_best_q <= '1;
      rank_idx_q  <= 4'd0;
    end else begin
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      rank_best_q <= rank_best_d;
      rank_idx_q  <= rank_idx_d;
    end
  end

  // In DECIDE best_q/best_idx_q hold the suit winner
  always_comb begin
    cand_s   = {best_idx_q[1:0], rank_idx_q};
    reject_s = (rank_best_q > MAX_C);
  end

`ifdef CARD_DECIDER_HYST_EN
  localparam logic [3:0] STABLE_C = 4'(STABLE_FRAMES);

  logic [3:0] cnt_q, cnt_d;
  logic [5:0] stored_q, stored_d;
  logic       stored_vld_q, stored_vld_d;

  always_comb begin
    cnt_d        = cnt_q;
    stored_d     = stored_q;
    stored_vld_d = stored_vld_q;
    if (decide_s) begin
      if (reject_s) begin
        cnt_d        = 4'd0;
        stored_d     = 6'd0;
        stored_vld_d = 1'b0;
      end else if (stored_vld_q && (cand_s == stored_q)) begin
        if (cnt_q >= STABLE_C) cnt_d = STABLE_C; else cnt_d = cnt_q + 4'd1;
      end else begin
        stored_d     = cand_s;
        stored_vld_d = 1'b1;
        cnt_d        = 4'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
    publish_s = decide_s && !reject_s && (cnt_d == STABLE_C) && (cand_s != card_map_q);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q        <= 4'd0;
      stored_q     <= 6'd0;
      stored_vld_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      stored_q     <= stored_d;
      stored_vld_q <= stored_vld_d;
    end
  end
`else
  always_comb begin
    publish_s = decide_s && !reject_s && (cand_s != card_map_q);
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      card_map_q   <= 6'd0;
      rank_score_q <= '0;
      suit_score_q <= '0;
      card_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      card_valid_q <= publish_s;
      busy_q       <= busy_d;
      if (publish_s) begin
        card_map_q   <= cand_s;
        rank_score_q <= rank_best_q;
        suit_score_q <= best_q;
      end
    end
  end

  assign card_map_out   = card_map_q;
  assign rank_score_out = rank_score_q;
  assign suit_score_out = suit_score_q;
  assign card_valid_out = card_valid_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_card_decider.sv
// Directed bench for card_decider; expectations follow CARD_DECIDER_HYST_EN (3 frames) or immediate update.
module tb_card_decider;
  localparam int SW  = 11;
  localparam int WIN = 30;
`ifdef CARD_DECIDER_HYST_EN
  localparam int NEED = 3;
`else
  localparam int NEED = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            fd  = 1'b0;
  logic [13*SW-1:0] rank_s = '0;
  logic [4*SW-1:0]  suit_s = '0;
  logic [5:0]      map;
  logic [SW-1:0]   rscore, sscore;
  logic            valid, busy;

  int errors = 0;
  int checks = 0;
  logic       busy_h  [WIN+1];
  logic       valid_h [WIN+1];
  logic [5:0] map_h   [WIN+1];

  card_decider #(.SCORE_W(SW), .MAX_SCORE(1500), .STABLE_FRAMES(3)) dut (
    .clk_in(clk), .rst_in(rst), .frame_done_in(fd),
    .rank_scores_in(rank_s), .suit_scores_in(suit_s),
    .card_map_out(map), .rank_score_out(rscore), .suit_score_out(sscore),
    .card_valid_out(valid), .busy_out(busy)
  );

  always #5 clk = ~clk;

  task automatic load_scores(input int rb, input int i0, input int v0, input int i1, input int v1,
                             input int s0, input int s1, input int s2, input int s3);
    for (int i = 0; i < 13; i++) rank_s[i*SW +: SW] = SW'(rb);
    rank_s[i0*SW +: SW] = SW'(v0);
    rank_s[i1*SW +: SW] = SW'(v1);
    suit_s[0*SW +: SW] = SW'(s0);
    suit_s[1*SW +: SW] = SW'(s1);
    suit_s[2*SW +: SW] = SW'(s2);
    suit_s[3*SW +: SW] = SW'(s3);
  endtask

  // Pulse frame_done during cycle 0, record cycles 0..WIN; optional extra pulse / reset at given cycles
  task automatic run_frame(input int inj_fd, input int inj_rst);
    @(negedge clk);
    busy_h[0] = busy; valid_h[0] = valid; map_h[0] = map;
    fd = 1'b1;
    for (int c = 1; c <= WIN; c++) begin
      @(negedge clk);
      busy_h[c] = busy; valid_h[c] = valid; map_h[c] = map;
      fd  = (c == inj_fd);
      rst = (c == inj_rst);
    end
    fd = 1'b0; rst = 1'b0;
  endtask

  function automatic int pulses();
    int n = 0;
    for (int c = 1; c <= WIN; c++) if (valid_h[c]) n++;
    return n;
  endfunction

  function automatic int busy_cycles();
    int n = 0;
    for (int c = 1; c <= WIN; c++) if (busy_h[c]) n++;
    return n;
  endfunction

  // Runs NEED-1 frames expecting no pulse, then a final frame that must pulse at cycle 20
  task automatic settle_frames(input string name, input int inj_fd);
    for (int f = 1; f < NEED; f++) begin
      run_frame(0, 0);
      checks++; if (pulses() !== 0) begin errors++; $display("FAIL %s_early%0d: got %0d pulses want 0", name, f, pulses()); end
    end
    run_frame(inj_fd, 0);
    checks++; if (valid_h[20] !== 1'b1) begin errors++; $display("FAIL %s_pulse20: got %0b want 1", name, valid_h[20]); end
    checks++; if (pulses() !== 1) begin errors++; $display("FAIL %s_pulses: got %0d want 1", name, pulses()); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (map !== 6'd0) begin errors++; $display("FAIL reset_map: got %0d want 0", map); end
    checks++; if (rscore !== 11'd0) begin errors++; $display("FAIL reset_rscore: got %0d want 0", rscore); end
    checks++; if (sscore !== 11'd0) begin errors++; $display("FAIL reset_sscore: got %0d want 0", sscore); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
  endtask

  task automatic test_basic();
    load_scores(400, 10, 120, 10, 120, 300, 300, 200, 320);
    settle_frames("basic", 0);
    checks++; if (busy_h[0] !== 1'b0) begin errors++; $display("FAIL basic_busy0: got %0b want 0", busy_h[0]); end
    checks++; if (busy_h[1] !== 1'b1) begin errors++; $display("FAIL basic_busy1: got %0b want 1", busy_h[1]); end
    checks++; if (busy_h[19] !== 1'b1) begin errors++; $display("FAIL basic_busy19: got %0b want 1", busy_h[19]); end
    checks++; if (busy_h[20] !== 1'b0) begin errors++; $display("FAIL basic_busy20: got %0b want 0", busy_h[20]); end
    checks++; if (busy_cycles() !== 19) begin errors++; $display("FAIL basic_busy_len: got %0d want 19", busy_cycles()); end
    checks++; if (valid_h[19] !== 1'b0) begin errors++; $display("FAIL basic_valid19: got %0b want 0", valid_h[19]); end
    checks++; if (valid_h[21] !== 1'b0) begin errors++; $display("FAIL basic_valid21: got %0b want 0", valid_h[21]); end
    checks++; if (map_h[19] !== 6'd0) begin errors++; $display("FAIL basic_map19: got %0d want 0", map_h[19]); end
    checks++; if (map_h[20] !== 6'b10_1010) begin errors++; $display("FAIL basic_map20: got %0d want 42", map_h[20]); end
    checks++; if (rscore !== 11'd120) begin errors++; $display("FAIL basic_rscore: got %0d want 120", rscore); end
    checks++; if (sscore !== 11'd200) begin errors++; $display("FAIL basic_sscore: got %0d want 200", sscore); end
    run_frame(0, 0);
    checks++; if (pulses() !== 0) begin errors++; $display("FAIL basic_repeat_pulse: got %0d want 0", pulses()); end
    checks++; if (map !== 6'b10_1010) begin errors++; $display("FAIL basic_repeat_map: got %0d want 42", map); end
  endtask

  task automatic test_ties();
    load_scores(400, 0, 90, 3, 90, 300, 250, 400, 250);
    settle_frames("ties", 0);
    checks++; if (map !== 6'b01_0000) begin errors++; $display("FAIL ties_map: got %0d want 16", map); end
    checks++; if (rscore !== 11'd90) begin errors++; $display("FAIL ties_rscore: got %0d want 90", rscore); end
    checks++; if (sscore !== 11'd250) begin errors++; $display("FAIL ties_sscore: got %0d want 250", sscore); end
  endtask

  task automatic test_reject();
    load_scores(400, 10, 120, 10, 120, 300, 300, 200, 320);
    settle_frames("rej_queen", 0);
    load_scores(400, 0, 90, 3, 90, 300, 250, 400, 250);
    for (int f = 1; f < NEED; f++) begin
      run_frame(0, 0);
      checks++; if (pulses() !== 0) begin errors++; $display("FAIL rej_pre%0d: got %0d pulses want 0", f, pulses()); end
    end
    // best rank 1501 is one above the limit
    load_scores(1600, 12, 1501, 12, 1501, 300, 250, 400, 250);
    run_frame(0, 0);
    checks++; if (pulses() !== 0) begin errors++; $display("FAIL rej_pulse: got %0d want 0", pulses()); end
    checks++; if (map !== 6'b10_1010) begin errors++; $display("FAIL rej_map: got %0d want 42", map); end
    checks++; if (rscore !== 11'd120) begin errors++; $display("FAIL rej_rscore: got %0d want 120", rscore); end
    checks++; if (sscore !== 11'd200) begin errors++; $display("FAIL rej_sscore: got %0d want 200", sscore); end
    load_scores(400, 0, 90, 3, 90, 300, 250, 400, 250);
    settle_frames("rej_after", 0);
    checks++; if (map !== 6'b01_0000) begin errors++; $display("FAIL rej_after_map: got %0d want 16", map); end
    // exactly at the limit is accepted
    load_scores(1600, 11, 1500, 11, 1500, 300, 300, 200, 320);
    settle_frames("limit", 0);
    checks++; if (map !== 6'b10_1011) begin errors++; $display("FAIL limit_map: got %0d want 43", map); end
    checks++; if (rscore !== 11'd1500) begin errors++; $display("FAIL limit_rscore: got %0d want 1500", rscore); end
  endtask

  task automatic test_drop();
    load_scores(400, 10, 120, 10, 120, 300, 300, 200, 320);
    settle_frames("drop", 10);
    checks++; if (busy_cycles() !== 19) begin errors++; $display("FAIL drop_busy_len: got %0d want 19", busy_cycles()); end
    checks++; if (busy_h[19] !== 1'b1) begin errors++; $display("FAIL drop_busy19: got %0b want 1", busy_h[19]); end
    checks++; if (busy_h[21] !== 1'b0) begin errors++; $display("FAIL drop_busy21: got %0b want 0", busy_h[21]); end
    checks++; if (map !== 6'b10_1010) begin errors++; $display("FAIL drop_map: got %0d want 42", map); end
  endtask

  task automatic test_rst_mid();
    load_scores(400, 0, 90, 3, 90, 300, 250, 400, 250);
    run_frame(0, 8);
    checks++; if (busy_h[8] !== 1'b1) begin errors++; $display("FAIL rstmid_busy8: got %0b want 1", busy_h[8]); end
    checks++; if (busy_h[9] !== 1'b0) begin errors++; $display("FAIL rstmid_busy9: got %0b want 0", busy_h[9]); end
    checks++; if (map_h[9] !== 6'd0) begin errors++; $display("FAIL rstmid_map9: got %0d want 0", map_h[9]); end
    checks++; if (pulses() !== 0) begin errors++; $display("FAIL rstmid_pulse: got %0d want 0", pulses()); end
    checks++; if (busy_cycles() !== 8) begin errors++; $display("FAIL rstmid_busy_len: got %0d want 8", busy_cycles()); end
    checks++; if (rscore !== 11'd0) begin errors++; $display("FAIL rstmid_rscore: got %0d want 0", rscore); end
    checks++; if (sscore !== 11'd0) begin errors++; $display("FAIL rstmid_sscore: got %0d want 0", sscore); end
    load_scores(400, 10, 120, 10, 120, 300, 300, 200, 320);
    settle_frames("rstmid_after", 0);
    checks++; if (map_h[20] !== 6'b10_1010) begin errors++; $display("FAIL rstmid_after_map: got %0d want 42", map_h[20]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_reject();
    test_drop();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/card_decider.md
# card_decider

Frame-rate decision stage directly downstream of the thirteen rank XOR kernels and the suit scores. On each frame boundary it snapshots every score and serially scans for the lowest rank and suit score. It rejects frames whose best rank score exceeds a limit and applies an N-frame stability filter. The stable `{suit, rank}` result drives the seven-segment controller.

## Interface
Parameters:
- `SCORE_W`, 11: width of every score input.
- `MAX_SCORE`, 1500: best rank score strictly above this marks the frame "no card".
- `STABLE_FRAMES`, 3: consecutive identical candidates required before the output updates (range 1–15).

Ports:
- `clk_in` input 1: system clock, 65 MHz pixel clock. One clock domain only.
- `rst_in` input 1: reset, synchronous, active-high.
- `frame_done_in` input 1: one-cycle pulse marking the end of a frame's score accumulation.
- `rank_scores_in` input 13*SCORE_W: flattened rank scores. Slice i = `[i*SCORE_W +: SCORE_W]`; i=0 is two … i=8 is ten, 9 is jack, 10 is queen, 11 is king, 12 is ace.
- `suit_scores_in` input 4*SCORE_W: flattened suit scores. Slice 0 spade, 1 diamond, 2 heart, 3 club.
- `card_map_out` output 6: stable result `{suit[1:0], rank[3:0]}`, with rank coded 0–12 as above.
- `rank_score_out` output SCORE_W: winning rank score belonging to `card_map_out`.
- `suit_score_out` output SCORE_W: winning suit score belonging to `card_map_out`.
- `card_valid_out` output 1: one-cycle pulse when `card_map_out` changes.
- `busy_out` output 1: high while a scan is in progress.

## Operation
- States:
  - IDLE → SNAP → SCAN_RANK → SCAN_SUIT → DECIDE → IDLE.
- IDLE:
  - Waits for `frame_done_in`.
  - On the pulse, registers all 17 scores into a snapshot bank, because the kernels may clear their scores afterwards.
  - Moves to SCAN_RANK with index=0, best=all-ones, best_idx=0.
- SCAN_RANK:
  - Handles one index per cycle, i=0..12.
  - Updates when `snap[i] < best`, a strict compare, so on a tie the lower index wins.
  - After i=12, goes to SCAN_SUIT with index and best reset.
- SCAN_SUIT:
  - Same rule as SCAN_RANK over i=0..3.
  - After i=3, goes to DECIDE.
- DECIDE:
  - If best rank score > `MAX_SCORE`, the frame is a reject: stable counter := 0, stored candidate cleared, outputs unchanged.
  - Otherwise, if the candidate `{suit, rank}` equals the stored candidate, counter := min(counter+1, `STABLE_FRAMES`).
  - Otherwise, stored candidate := new candidate and counter := 1.
  - When the counter equals `STABLE_FRAMES` and the candidate differs from `card_map_out`:
    - load `card_map_out`, `rank_score_out` and `suit_score_out`;
    - pulse `card_valid_out`.
  - An unchanged card produces no pulse.
- `frame_done_in` outside IDLE is ignored; the frame is dropped, with no queuing.
- Arithmetic:
  - Unsigned compares only.
  - The counter is 4 bits and saturates; it never wraps.
- Reset values:
  - state IDLE, counter 0, stored candidate invalid;
  - `card_map_out` 0, `rank_score_out` 0, `suit_score_out` 0;
  - `card_valid_out` 0, `busy_out` 0.
- `rst_in` mid-scan aborts the scan immediately. The next cycle is IDLE with all reset values.

## Timing
- Cycle 0: `frame_done_in` sampled high in IDLE.
- Cycle 1: SNAP; snapshot valid.
- Cycles 2–14: SCAN_RANK.
- Cycles 15–18: SCAN_SUIT.
- Cycle 19: DECIDE.
- Cycle 20: outputs and `card_valid_out` visible.
- Total latency from `frame_done_in` to output: 20 cycles.
- `busy_out` is high on cycles 1–19 and is registered.
- Earliest next accepted `frame_done_in`: cycle 20.
- `card_valid_out` is high for exactly one cycle, the same cycle the new `card_map_out` first appears.

## Configuration
- `CARD_DECIDER_HYST_EN` defined:
  - the stability filter operates as described;
  - `STABLE_FRAMES` is honoured.
- `CARD_DECIDER_HYST_EN` undefined:
  - the counter logic is removed;
  - every non-reject DECIDE whose candidate differs from `card_map_out` updates the outputs and pulses `card_valid_out` immediately, equivalent to `STABLE_FRAMES`=1;
  - a reject still leaves the outputs unchanged.

## Test plan
- Rank scores all 400 except queen (i=10)=120, suit scores {300,300,200,320}, one frame, HYST undefined → at cycle 20 `card_map_out`=6'b10_1010, `rank_score_out`=120, `suit_score_out`=200, `card_valid_out` pulse.
- Same scores for 3 frames, HYST defined, `STABLE_FRAMES`=3 → no pulse after frames 1–2; pulse after frame 3 only; a 4th identical frame gives no pulse.
- Ranks two and five both at a minimum of 90 → rank=0 (lowest index wins); suit ties at 250 on diamond and club → suit=1.
- All rank scores 1600 (> `MAX_SCORE`) after a stable queen/heart → outputs hold at 6'b10_1010, no pulse, counter cleared, so the next good queen frame needs 3 more frames.
- Second `frame_done_in` at cycle 10 of a scan → ignored; `busy_out` stays high through cycle 19; exactly one DECIDE.
- `rst_in` asserted at cycle 8 of a scan → next cycle `busy_out`=0, outputs 0, a later frame scans normally from IDLE.
